// File: rtl/tc_clk_gate_ctrl.sv
// Enable controller for one clock-gated domain: wakes the gate on request, reports
// when the gated clock is stable, and switches it off after a run of idle cycles.
module tc_clk_gate_ctrl #(
  parameter int IDLE_CNT = 16,
  parameter int WAKE_CNT = 2,
  parameter int STAT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              busy_i,
  input  logic              force_on_i,
  output logic              gate_en_o,
  output logic              ready_o,
  output logic [1:0]        state_o,
  output logic [STAT_W-1:0] wakeups_o
);

  // state | meaning
  // OFF   | gate closed, waiting for req_i or force_on_i
  // WAKE  | gate open, waiting WAKE_CNT cycles for the gated clock to settle
  // ON    | clock stable, counting consecutive idle cycles
  // DRAIN | one-cycle grace period before closing the gate

  localparam int IW     = $clog2(IDLE_CNT + 1);
  localparam int WW_RAW = $clog2(WAKE_CNT + 1);
  localparam int WW     = (WW_RAW < 1) ? 1 : WW_RAW;

  // The wake counter is loaded one short so that terminal count zero lands on t0+WAKE_CNT.
  localparam logic [WW-1:0]     WAKE_LOAD = WW'((WAKE_CNT > 0) ? WAKE_CNT - 1 : 0);
  localparam logic [IW-1:0]     IDLE_LAST = IW'(IDLE_CNT - 1);
  localparam logic [STAT_W-1:0] STAT_MAX  = '1;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_WAKE  = 2'd1,
    S_ON    = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     wake_q, wake_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [STAT_W-1:0] wakeups_q, wakeups_d;
  logic              gate_q, ready_q;
  logic              act;

  assign act = req_i | busy_i | force_on_i;

  always_comb begin
    state_d   = state_q;
    wake_d    = wake_q;
    idle_d    = idle_q;
    wakeups_d = wakeups_q;
    case (state_q)
      S_OFF: begin
        idle_d = '0;
        if (req_i | force_on_i) begin
          state_d = (WAKE_CNT == 0) ? S_ON : S_WAKE;
          wake_d  = WAKE_LOAD;
          if (wakeups_q != STAT_MAX) begin
            wakeups_d = wakeups_q + 1'b1;
          end
        end
      end
      S_WAKE: begin
        idle_d = '0;
        if (wake_q == '0) begin
          state_d = S_ON;
        end else begin
          wake_d = wake_q - 1'b1;
        end
      end
      S_ON: begin
        if (act) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          state_d = S_DRAIN;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_DRAIN: begin
        idle_d  = '0;
        state_d = act ? S_ON : S_OFF;
      end
      default: begin
        state_d = S_OFF;
        idle_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_OFF;
      wake_q    <= '0;
      idle_q    <= '0;
      wakeups_q <= '0;
      gate_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wake_q    <= wake_d;
      idle_q    <= idle_d;
      wakeups_q <= wakeups_d;
      gate_q    <= (state_d != S_OFF);
      ready_q   <= (state_d == S_ON);
    end
  end

  assign gate_en_o = gate_q;
  assign ready_o   = ready_q;
  assign state_o   = state_q;
  assign wakeups_o = wakeups_q;

endmodule

// File: tb/tb_tc_clk_gate_ctrl.sv
// Randomised scoreboard bench for tc_clk_gate_ctrl with a cycle-count reference model.
module tb_tc_clk_gate_ctrl;

  localparam int IDLE_CNT = 4;
  localparam int WAKE_CNT = 2;
  localparam int STAT_W   = 2;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              req_i = 1'b0;
  logic              busy_i = 1'b0;
  logic              force_on_i = 1'b0;
  logic              gate_en_o;
  logic              ready_o;
  logic [1:0]        state_o;
  logic [STAT_W-1:0] wakeups_o;

  tc_clk_gate_ctrl #(
    .IDLE_CNT(IDLE_CNT),
    .WAKE_CNT(WAKE_CNT),
    .STAT_W  (STAT_W)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .busy_i    (busy_i),
    .force_on_i(force_on_i),
    .gate_en_o (gate_en_o),
    .ready_o   (ready_o),
    .state_o   (state_o),
    .wakeups_o (wakeups_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int gate;
    int ready;
    int st;
    int wk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: mode 0=OFF 1=WAKE 2=ON 3=DRAIN, driven by absolute cycle numbers.
  int m_mode     = 0;
  int m_cycle    = 0;
  int m_ready_at = 0;
  int m_streak   = 0;
  int m_wakes    = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  always @(negedge rst_ni) begin
    m_mode   = 0;
    m_streak = 0;
    m_wakes  = 0;
    exp_q.delete();
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      bit   act;
      exp_t e;
      act = req_i | busy_i | force_on_i;
      m_cycle++;
      case (m_mode)
        0: if (req_i || force_on_i) begin
             if (m_wakes < STAT_MAX) m_wakes++;
             if (WAKE_CNT == 0) begin
               m_mode = 2;
             end else begin
               m_mode     = 1;
               m_ready_at = m_cycle + WAKE_CNT;
             end
             m_streak = 0;
           end
        1: if (m_cycle == m_ready_at) m_mode = 2;
        2: begin
             m_streak = act ? 0 : m_streak + 1;
             if (m_streak == IDLE_CNT) begin
               m_mode   = 3;
               m_streak = 0;
             end
           end
        default: m_mode = act ? 2 : 0;
      endcase
      e.gate  = (m_mode != 0) ? 1 : 0;
      e.ready = (m_mode == 2) ? 1 : 0;
      e.st    = m_mode;
      e.wk    = m_wakes;
      exp_q.push_back(e);
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("gate_en", int'(gate_en_o), e.gate);
      check("ready", int'(ready_o), e.ready);
      check("state", int'(state_o), e.st);
      check("wakeups", int'(wakeups_o), e.wk);
    end
  end

  task automatic drive(input bit r, input bit b, input bit f, input int n);
    req_i      = r;
    busy_i     = b;
    force_on_i = f;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gate_en"}, int'(gate_en_o), 0);
    check({tag, "_ready"}, int'(ready_o), 0);
    check({tag, "_state"}, int'(state_o), 0);
    check({tag, "_wakeups"}, int'(wakeups_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("in_reset");
    rst_ni = 1'b1;

    // quiet after reset, then wake and idle back off
    drive(0, 0, 0, 20);
    drive(1, 0, 0, 4);
    drive(0, 0, 0, 10);

    // rescue from DRAIN
    drive(1, 0, 0, 3);
    req_i  = 1'b0;
    waited = 0;
    while (state_o != 2'd3 && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    check("drain_reached", int'(state_o), 3);
    drive(1, 0, 0, 2);
    drive(0, 0, 0, 10);

    // sparse busy activity keeps the clock on, then force_on
    drive(1, 0, 0, 3);
    for (int i = 0; i < 50; i++) drive(0, (i % 3) == 0, 0, 1);
    drive(0, 0, 1, 100);
    drive(0, 0, 0, 10);

    // asynchronous reset while waking
    drive(1, 0, 0, 1);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("async_rst");
    req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 0, 0, 5);

    // saturating wake-up counter
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 3);
      drive(0, 0, 0, 8);
    end

    // random segments
    for (int seg = 0; seg < 600; seg++) begin
      int len;
      bit r, b, f;
      len = $urandom_range(1, 8);
      r   = ($urandom_range(0, 9) < 3);
      b   = ($urandom_range(0, 9) < 2);
      f   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) begin
        r = 0;
        b = 0;
        f = 0;
        len = len + IDLE_CNT;
      end
      drive(r, b, f, len);
      if ($urandom_range(0, 99) == 0) begin
        #($urandom_range(1, 8)) rst_ni = 1'b0;
        #1 check_reset_outputs("rand_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
      end
    end
    drive(0, 0, 0, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
